// File: rtl/ysyx_23060191_wbu_pkg.sv
// Shared constants and helpers for the write-back unit.
//   WBU_CPU_WIDTH : default data/PC width
//   WB_ENTRY_W    : FIFO entry width at the default CPU width, {rd, wen, data, pc}
//   wb_entry_w()  : FIFO entry width for any CPU width
package ysyx_23060191_wbu_pkg;

  localparam int WBU_CPU_WIDTH = 32;
  localparam int WB_ENTRY_W    = 5 + 1 + 2 * WBU_CPU_WIDTH;

  function automatic int wb_entry_w(input int cpu_width);
    return 5 + 1 + 2 * cpu_width;
  endfunction

endpackage

// File: rtl/ysyx_23060191_wb_fifo.sv
// Generic synchronous FIFO used as the write-back queue.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   i_push, i_pop   : enqueue i_din / dequeue the head (ignored when full / empty)
//   o_dout          : head entry (raw storage; the caller gates it when empty)
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries, 0..DEPTH
//   o_valid         : per-slot occupied bit
//   o_tags          : top TAG_W bits of every slot, so the caller can snoop queued entries
module ysyx_23060191_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DEPTH-1:0]       o_valid,
  output logic [DEPTH*TAG_W-1:0] o_tags
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  // Push is refused at full even if a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr]   <= i_din;
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + PTR_W'(1);
      end
      // Push and pop never target the same slot: that needs empty or full.
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_valid = r_valid;

  always_comb begin
    o_tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_tags[i*TAG_W +: TAG_W] = r_mem[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/ysyx_23060191_wbu.sv
// Write-back unit: queues EXU/LSU results in order and retires one per commit
// handshake onto the GPR Rd write port.
// Ports:
//   i_exu_* / o_exu_ready : EXU result channel (lower priority)
//   i_lsu_* / o_lsu_ready : LSU result channel (higher priority)
//   o_wr_en_Rd, o_addr_Rd, o_data_Rd : GPR write port, write fires on the pop edge
//   o_commit_valid, i_commit_ready, o_commit_pc : retirement handshake
//   o_busy_mask : registers with a pending write in the queue
module ysyx_23060191_wbu
  import ysyx_23060191_wbu_pkg::*;
#(
  parameter int CPU_WIDTH = WBU_CPU_WIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_exu_valid,
  output logic                 o_exu_ready,
  input  logic [4:0]           i_exu_rd,
  input  logic                 i_exu_wen,
  input  logic [CPU_WIDTH-1:0] i_exu_data,
  input  logic [CPU_WIDTH-1:0] i_exu_pc,
  input  logic                 i_lsu_valid,
  output logic                 o_lsu_ready,
  input  logic [4:0]           i_lsu_rd,
  input  logic                 i_lsu_wen,
  input  logic [CPU_WIDTH-1:0] i_lsu_data,
  input  logic [CPU_WIDTH-1:0] i_lsu_pc,
  output logic                 o_wr_en_Rd,
  output logic [4:0]           o_addr_Rd,
  output logic [CPU_WIDTH-1:0] o_data_Rd,
  output logic                 o_commit_valid,
  input  logic                 i_commit_ready,
  output logic [CPU_WIDTH-1:0] o_commit_pc,
  output logic [31:0]          o_busy_mask
);

  localparam int ENTRY_W = wb_entry_w(CPU_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TAG_W   = 6;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [DEPTH-1:0]   w_valid;
  logic [DEPTH*TAG_W-1:0] w_tags;
  logic               w_head_wen;

  assign o_lsu_ready = !w_full;
  assign o_exu_ready = !w_full && !i_lsu_valid;
  assign w_push = (i_lsu_valid && o_lsu_ready) || (i_exu_valid && o_exu_ready);

  // Entry layout {rd, wen, data, pc}; x0 writes are stored with wen cleared.
  always_comb begin
    if (i_lsu_valid) begin
      w_din = {i_lsu_rd, i_lsu_wen && (i_lsu_rd != 5'd0), i_lsu_data, i_lsu_pc};
    end else begin
      w_din = {i_exu_rd, i_exu_wen && (i_exu_rd != 5'd0), i_exu_data, i_exu_pc};
    end
  end

  ysyx_23060191_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_tags  (w_tags)
  );

  assign o_commit_valid = (w_count != '0);
  assign w_pop          = o_commit_valid && i_commit_ready;

  assign w_head      = w_empty ? '0 : w_dout;
  assign o_addr_Rd   = w_head[ENTRY_W-1 -: 5];
  assign w_head_wen  = w_head[ENTRY_W-6];
  assign o_data_Rd   = w_head[2*CPU_WIDTH-1 -: CPU_WIDTH];
  assign o_commit_pc = w_head[CPU_WIDTH-1:0];

  // Queued entries are flushed by reset, so their write must not leak out.
  assign o_wr_en_Rd = w_pop && w_head_wen && !rst;

  // Tag of each slot is {rd, wen}.
  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && w_tags[i*TAG_W]) begin
        o_busy_mask[w_tags[i*TAG_W+1 +: 5]] = 1'b1;
      end
    end
    o_busy_mask[0] = 1'b0;
  end

endmodule
